interrupt_controller: RTL

- Sits directly upstream of the processor top and drives its interrupt_signal input.
- Edge-detects and latches external interrupt requests, applies a per-source mask and a global enable, and picks the highest-priority pending source.
- Asserts interrupt_signal for a fixed pulse length, then holds off further dispatch until the processor signals return-from-interrupt.

---
 rtl/intc_pkg.sv | 23 ++
 rtl/irq_priority_encoder.sv | 29 ++
 rtl/interrupt_controller.sv | 120 ++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types, constants and helpers for the interrupt controller
// Contents: controller FSM state enum, pulse counter width, onehot() decode helper.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    localparam int PULSE_CNT_W = 4;
    localparam int MAX_SRC     = 16;

    // Decode a source ID into a one-hot vector at the maximum supported source
    // count; callers truncate to their own NUM_SRC.
    function automatic logic [MAX_SRC-1:0] onehot(input logic [3:0] id);
        logic [MAX_SRC-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - combinational lowest-index-wins priority encoder
// Ports:
//   elig  in  NUM_SRC  eligible request bits
//   valid out 1        any bit of elig set
//   id    out ID_W     index of the lowest set bit (0 when none)
module irq_priority_encoder
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] elig,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-latched, masked, prioritised interrupt dispatcher
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   irq_in            raw request lines, rising edge = request
//   gie               global enable for dispatch
//   mask_we/wdata     mask register write (bit=1 enables a source)
//   irq_done          return-from-interrupt pulse from the processor
//   interrupt_signal  registered pulse, PULSE_LEN cycles per dispatch
//   int_id            ID of the source being serviced
//   pending           latched pending bits
//   busy              high while a dispatch is in progress
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int PULSE_LEN = 2,
    parameter int ID_W      = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               gie,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               irq_done,
    output logic               interrupt_signal,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    intc_state_e            state_q, state_d;
    logic [NUM_SRC-1:0]     irq_prev_q;
    logic [NUM_SRC-1:0]     pending_q, pending_d;
    logic [NUM_SRC-1:0]     mask_q, mask_d;
    logic [PULSE_CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]        int_id_q, int_id_d;
    logic                   intsig_q, intsig_d;

    logic [NUM_SRC-1:0]     rise;
    logic [NUM_SRC-1:0]     clr;
    logic                   win_valid;
    logic [ID_W-1:0]        win_id;

    assign rise = irq_in & ~irq_prev_q;

    irq_priority_encoder #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio (
        .elig  (pending_q & mask_q),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        intsig_d = intsig_q;
        int_id_d = int_id_q;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (gie && win_valid) begin
                    state_d  = ASSERT;
                    int_id_d = win_id;
                    clr      = NUM_SRC'(onehot(4'(win_id)));
                    intsig_d = 1'b1;
                    cnt_d    = PULSE_CNT_W'(PULSE_LEN - 1);
                end
            end
            ASSERT: begin
                if (cnt_q == '0) begin
                    intsig_d = 1'b0;
                    state_d  = SERVICE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                intsig_d = 1'b0;
            end
        endcase
        // A new rise on the bit being dispatched this cycle is kept pending.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            cnt_q      <= '0;
            int_id_q   <= '0;
            intsig_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            int_id_q   <= int_id_d;
            intsig_q   <= intsig_d;
        end
    end

    assign interrupt_signal = intsig_q;
    assign int_id           = int_id_q;
    assign pending          = pending_q;
    assign busy             = (state_q != IDLE);

endmodule
